// File: rtl/cam_cfg_seq.sv
// rtl/cam_cfg_seq.sv - HM0360 register-table sequencer driving the SB_I2C system bus
// Programs the I2C core, then writes each table entry as a 7-bit-addressed 16-bit register write.
module cam_cfg_seq #(
  parameter int unsigned NUM_REGS_P     = 64,
  parameter logic [6:0]  DEV_ADDR_P     = 7'h24,
  parameter logic [9:0]  BR_DIV_P       = 10'd60,
  parameter int unsigned DELAY_UNIT_P   = 12000,
  parameter int unsigned POLL_TIMEOUT_P = 65535,
  localparam int unsigned IW = (NUM_REGS_P > 1) ? $clog2(NUM_REGS_P) : 1
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  output logic [IW-1:0] tbl_addr_o,
  input  logic [23:0]   tbl_data_i,
  output logic          sbstb_o,
  output logic          sbrw_o,
  output logic [7:0]    sbadr_o,
  output logic [7:0]    sbdat_o,
  input  logic [7:0]    sbdat_i,
  input  logic          sback_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic [IW-1:0] err_idx_o
);

  localparam int unsigned PW = $clog2(POLL_TIMEOUT_P + 1);
  localparam int unsigned DW = (DELAY_UNIT_P > 1) ? $clog2(DELAY_UNIT_P) : 1;
  localparam logic [PW-1:0] POLL_MAX = PW'(POLL_TIMEOUT_P);
  localparam logic [DW-1:0] DLY_MAX  = DW'(DELAY_UNIT_P - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REGS_P - 1);

  localparam logic [7:0] A_CR1   = 8'h18;
  localparam logic [7:0] A_CMDR  = 8'h19;
  localparam logic [7:0] A_BRLSB = 8'h1A;
  localparam logic [7:0] A_BRMSB = 8'h1B;
  localparam logic [7:0] A_SR    = 8'h1C;
  localparam logic [7:0] A_TXDR  = 8'h1D;

  localparam logic [7:0] CMD_STA_WR = 8'h90;
  localparam logic [7:0] CMD_WR     = 8'h10;
  localparam logic [7:0] CMD_STO    = 8'h40;
  localparam logic [7:0] CR1_EN     = 8'h80;

  localparam int SR_TIP   = 7;
  localparam int SR_BUSY  = 6;
  localparam int SR_RARC  = 5;
  localparam int SR_TRRDY = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_FETCH, S_LATCH, S_XFER, S_STOP, S_SPOLL,
    S_ESTOP, S_DELAY, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [23:0]   ent_q, ent_d;
  logic [1:0]    byte_q, byte_d;
  logic [1:0]    ph_q, ph_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [DW-1:0] tick_q, tick_d;
  logic [7:0]    units_q, units_d;
  logic          stb_q, stb_d;
  logic          rw_q, rw_d;
  logic [7:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic          gap_q, gap_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [IW-1:0] err_idx_q, err_idx_d;

  logic       req;
  logic       req_rw;
  logic [7:0] req_adr;
  logic [7:0] req_dat;
  logic       to_err;
  logic       acked;
  logic [7:0] byte_val;
  logic       unused_sr;

  assign acked     = stb_q & sback_i;
  assign unused_sr = ^{sbdat_i[4:3], sbdat_i[1:0]};

  always_comb begin
    byte_val = ent_q[7:0];
    case (byte_q)
      2'd0:    byte_val = {DEV_ADDR_P, 1'b0};
      2'd1:    byte_val = ent_q[23:16];
      2'd2:    byte_val = ent_q[15:8];
      default: byte_val = ent_q[7:0];
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ent_d      = ent_q;
    byte_d     = byte_q;
    ph_d       = ph_q;
    poll_cnt_d = poll_cnt_q;
    tick_d     = tick_q;
    units_d    = units_q;
    stb_d      = stb_q;
    rw_d       = rw_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    gap_d      = gap_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    req        = 1'b0;
    req_rw     = 1'b1;
    req_adr    = 8'h00;
    req_dat    = 8'h00;
    to_err     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d   = S_INIT;
          idx_d     = '0;
          ph_d      = 2'd0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = '0;
        end
      end
      S_INIT: begin
        req = 1'b1;
        case (ph_q)
          2'd0:    begin req_adr = A_BRLSB; req_dat = BR_DIV_P[7:0]; end
          2'd1:    begin req_adr = A_BRMSB; req_dat = {6'b0, BR_DIV_P[9:8]}; end
          default: begin req_adr = A_CR1;   req_dat = CR1_EN; end
        endcase
        if (acked) begin
          if (ph_q == 2'd2) begin
            ph_d    = 2'd0;
            state_d = S_FETCH;
          end else begin
            ph_d = ph_q + 2'd1;
          end
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        ent_d = tbl_data_i;
        if (tbl_data_i[23:8] == 16'hFFFF) begin
          units_d = tbl_data_i[7:0];
          tick_d  = '0;
          state_d = (tbl_data_i[7:0] == 8'd0) ? S_NEXT : S_DELAY;
        end else begin
          byte_d  = 2'd0;
          ph_d    = 2'd0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        req = 1'b1;
        case (ph_q)
          2'd0: begin
            req_adr = A_TXDR;
            req_dat = byte_val;
            if (acked) ph_d = 2'd1;
          end
          2'd1: begin
            req_adr = A_CMDR;
            req_dat = (byte_q == 2'd0) ? CMD_STA_WR : CMD_WR;
            if (acked) begin
              ph_d       = 2'd2;
              poll_cnt_d = '0;
            end
          end
          default: begin
            req_rw     = 1'b0;
            req_adr    = A_SR;
            poll_cnt_d = poll_cnt_q + PW'(1);
            if (acked && sbdat_i[SR_TRRDY]) begin
              if (sbdat_i[SR_RARC]) begin
                state_d = S_ESTOP;
              end else if (byte_q == 2'd3) begin
                state_d = S_STOP;
              end else begin
                byte_d = byte_q + 2'd1;
                ph_d   = 2'd0;
              end
            end else if (poll_cnt_q == POLL_MAX) begin
              to_err = 1'b1;
            end
          end
        endcase
      end
      S_STOP: begin
        req     = 1'b1;
        req_adr = A_CMDR;
        req_dat = CMD_STO;
        if (acked) begin
          poll_cnt_d = '0;
          state_d    = S_SPOLL;
        end
      end
      S_SPOLL: begin
        req        = 1'b1;
        req_rw     = 1'b0;
        req_adr    = A_SR;
        poll_cnt_d = poll_cnt_q + PW'(1);
        if (acked && !sbdat_i[SR_BUSY] && !sbdat_i[SR_TIP]) begin
          state_d = S_NEXT;
        end else if (poll_cnt_q == POLL_MAX) begin
          to_err = 1'b1;
        end
      end
      // Slave refused a byte: release the bus before reporting.
      S_ESTOP: begin
        req     = 1'b1;
        req_adr = A_CMDR;
        req_dat = CMD_STO;
        if (acked) to_err = 1'b1;
      end
      S_DELAY: begin
        if (tick_q == DLY_MAX) begin
          tick_d  = '0;
          units_d = units_q - 8'd1;
          if (units_q == 8'd1) state_d = S_NEXT;
        end else begin
          tick_d = tick_q + DW'(1);
        end
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bus access engine: hold until ack, drop next cycle, then one idle cycle.
    if (to_err) begin
      state_d   = S_ERR;
      err_d     = 1'b1;
      err_idx_d = idx_q;
      busy_d    = 1'b0;
      stb_d     = 1'b0;
      gap_d     = 1'b0;
    end else if (stb_q) begin
      if (sback_i) begin
        stb_d = 1'b0;
        gap_d = 1'b1;
      end
    end else if (gap_q) begin
      gap_d = 1'b0;
    end else if (req) begin
      stb_d = 1'b1;
      rw_d  = req_rw;
      adr_d = req_adr;
      dat_d = req_dat;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      ent_q      <= '0;
      byte_q     <= '0;
      ph_q       <= '0;
      poll_cnt_q <= '0;
      tick_q     <= '0;
      units_q    <= '0;
      stb_q      <= 1'b0;
      rw_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      gap_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ent_q      <= ent_d;
      byte_q     <= byte_d;
      ph_q       <= ph_d;
      poll_cnt_q <= poll_cnt_d;
      tick_q     <= tick_d;
      units_q    <= units_d;
      stb_q      <= stb_d;
      rw_q       <= rw_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      gap_q      <= gap_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign tbl_addr_o = idx_q;
  assign sbstb_o    = stb_q;
  assign sbrw_o     = rw_q;
  assign sbadr_o    = adr_q;
  assign sbdat_o    = dat_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_idx_o  = err_idx_q;

endmodule

// File: tb/tb_cam_cfg_seq.sv
// tb/tb_cam_cfg_seq.sv - directed bench for cam_cfg_seq with an SB_I2C bus model
module tb_cam_cfg_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  tbl_addr;
  logic [23:0] tbl_data;
  logic        sbstb, sbrw, sback;
  logic [7:0]  sbadr, sbdat_w, sbdat_r;
  logic        busy, done, err;
  logic [1:0]  err_idx;

  always #5 clk = ~clk;

  cam_cfg_seq #(
    .NUM_REGS_P(3), .DEV_ADDR_P(7'h24), .BR_DIV_P(10'd60),
    .DELAY_UNIT_P(100), .POLL_TIMEOUT_P(50)
  ) dut (
    .clk_i(clk), .rstn_i(rstn), .start_i(start),
    .tbl_addr_o(tbl_addr), .tbl_data_i(tbl_data),
    .sbstb_o(sbstb), .sbrw_o(sbrw), .sbadr_o(sbadr), .sbdat_o(sbdat_w),
    .sbdat_i(sbdat_r), .sback_i(sback),
    .busy_o(busy), .done_o(done), .err_o(err), .err_idx_o(err_idx)
  );

  logic [23:0] tbl [0:2];
  always @(posedge clk) tbl_data <= tbl[tbl_addr];

  int          ack_dly  = 2;
  bit          trrdy_en = 1'b1;
  int          rarc_at  = 0;
  bit          rarc;
  int          wcnt;
  int          since_cmd;
  int          ntx = 0;
  int          cyc = 0;
  logic [15:0] wlog [$];
  int          wcyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sback     <= 1'b0;
      wcnt      <= 0;
      since_cmd <= 1000;
      rarc      <= 1'b0;
      sbdat_r   <= 8'h00;
    end else begin
      sback <= 1'b0;
      if (rarc_at == 0) rarc <= 1'b0;
      if (since_cmd < 1000) since_cmd <= since_cmd + 1;
      if (sbstb && !sback) begin
        if (wcnt >= ack_dly - 1) begin
          sback <= 1'b1;
          wcnt  <= 0;
          if (sbrw) begin
            wlog.push_back({sbadr, sbdat_w});
            wcyc.push_back(cyc);
            if (sbadr == 8'h19) since_cmd <= 0;
            if (sbadr == 8'h1D) begin
              ntx <= ntx + 1;
              if (ntx + 1 == rarc_at) rarc <= 1'b1;
            end
          end else begin
            sbdat_r <= {1'b0, since_cmd < 20, rarc, 2'b00,
                        trrdy_en && (since_cmd >= 20), 2'b00};
          end
        end else begin
          wcnt <= wcnt + 1;
        end
      end else begin
        wcnt <= 0;
      end
    end
  end

  bit          mon_en = 1'b0;
  bit          prev_stb, prev_ack;
  logic [16:0] held;
  int          stab_err = 0;
  int          drop_err = 0;

  always @(negedge clk) begin
    if (rstn && mon_en) begin
      if (prev_stb && sbstb && !prev_ack && {sbrw, sbadr, sbdat_w} !== held) stab_err++;
      if (prev_ack && sbstb) drop_err++;
      if (prev_stb && !sbstb && !prev_ack) drop_err++;
    end
    prev_stb = sbstb;
    prev_ack = sbstb && sback;
    held     = {sbrw, sbadr, sbdat_w};
  end

  logic [15:0] exp_w [0:20] = '{
    16'h1A3C, 16'h1B00, 16'h1880,
    16'h1D48, 16'h1990, 16'h1D01, 16'h1910, 16'h1D03, 16'h1910, 16'h1D01, 16'h1910, 16'h1940,
    16'h1D48, 16'h1990, 16'h1D30, 16'h1910, 16'h1D24, 16'h1910, 16'h1D05, 16'h1910, 16'h1940
  };

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_start;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done || err) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic check_run(input int base, input string tag);
    check({tag, "_nwr"}, wlog.size() - base, 21);
    for (int i = 0; i < 21; i++)
      if (base + i < wlog.size())
        check($sformatf("%s_wr%0d", tag, i), wlog[base + i], exp_w[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, tx_base, gap, dt;
    bit to;

    tbl[0] = 24'h010301;
    tbl[1] = 24'hFFFF02;
    tbl[2] = 24'h302405;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_stb", sbstb, 0);
    check("rst_tbl_addr", tbl_addr, 0);
    check("rst_err_idx", err_idx, 0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_no_autostart", busy, 0);
    check("idle_no_writes", wlog.size(), 0);

    base = wlog.size();
    pulse_start;
    check("t1_busy", busy, 1);
    wait_end(5000, to);
    check("t1_timeout", to, 0);
    check("t1_done", done, 1);
    check("t1_err", err, 0);
    check("t1_busy_end", busy, 0);
    check_run(base, "t1");
    if (wlog.size() - base >= 13) begin
      gap = wcyc[base + 12] - wcyc[base + 11];
      check("t1_gap_min", gap >= 200, 1);
      check("t1_gap_max", gap <= 320, 1);
    end

    ack_dly = 7;
    mon_en  = 1'b1;
    base    = wlog.size();
    pulse_start;
    repeat (40) @(negedge clk);
    pulse_start;
    check("t2_busy_held", busy, 1);
    wait_end(8000, to);
    mon_en  = 1'b0;
    ack_dly = 2;
    check("t2_timeout", to, 0);
    check("t2_done", done, 1);
    check("t2_stable", stab_err, 0);
    check("t2_strobe_drop", drop_err, 0);
    check_run(base, "t2");

    tbl[1]  = 24'h302405;
    tbl[2]  = 24'h010001;
    tx_base = ntx;
    rarc_at = tx_base + 6;
    base    = wlog.size();
    pulse_start;
    wait_end(5000, to);
    repeat (30) @(negedge clk);
    check("t3_timeout", to, 0);
    check("t3_err", err, 1);
    check("t3_done", done, 0);
    check("t3_busy", busy, 0);
    check("t3_err_idx", err_idx, 1);
    check("t3_nwr", wlog.size() - base, 17);
    check("t3_last_sto", wlog[wlog.size() - 1], 16'h1940);
    check("t3_ntx", ntx - tx_base, 6);

    rarc_at = 0;
    tbl[1]  = 24'hFFFF02;
    tbl[2]  = 24'h302405;
    base    = wlog.size();
    pulse_start;
    check("t4_err_cleared", err, 0);
    check("t4_busy", busy, 1);
    wait_end(5000, to);
    check("t4_timeout", to, 0);
    check("t4_done", done, 1);
    check("t4_err", err, 0);
    check_run(base, "t4");

    trrdy_en = 1'b0;
    base     = wlog.size();
    pulse_start;
    wait_end(3000, to);
    check("t5_timeout", to, 0);
    check("t5_err", err, 1);
    check("t5_err_idx", err_idx, 0);
    check("t5_done", done, 0);
    check("t5_nwr", wlog.size() - base, 5);
    if (wlog.size() - base >= 5) begin
      check("t5_last_cmd", wlog[wlog.size() - 1], 16'h1990);
      dt = cyc - wcyc[base + 4];
      check("t5_latency_min", dt >= 50, 1);
      check("t5_latency_max", dt <= 80, 1);
    end
    repeat (5) @(negedge clk);
    check("t5_stb_low", sbstb, 0);
    check("t5_busy", busy, 0);

    trrdy_en = 1'b1;
    tx_base  = ntx;
    pulse_start;
    to = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ntx > tx_base) begin
        to = 1'b0;
        break;
      end
    end
    check("t6_reach_xfer", to, 0);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_stb", sbstb, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", err, 0);
    @(negedge clk) rstn = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle", busy, 0);
    base = wlog.size();
    pulse_start;
    wait_end(5000, to);
    check("t6_timeout", to, 0);
    check("t6_done", done, 1);
    if (wlog.size() > base) check("t6_first_brlsb", wlog[base], 16'h1A3C);
    check_run(base, "t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_cfg_seq.md
Name: cam_cfg_seq

Overview:
- Camera register configuration sequencer that drives the SB_I2C hard IP system bus to program the HM0360 over SCCB/I2C after reset.
- Walks an external register table of {reg_addr[15:0], value[7:0]} entries, one 7-bit-addressed write per entry, with delay pseudo-entries.
- Sits in the mclk_i domain alongside the SB_I2C instance and replaces its tied-off system-bus inputs. done_o gates downstream video enable.

Parameters:
- NUM_REGS_P, 64, number of table entries walked (index 0..NUM_REGS_P-1)
- DEV_ADDR_P, 7'h24, 7-bit camera I2C address
- BR_DIV_P, 10'd60, SB_I2C prescale value written to I2CBRMSB[1:0]/I2CBRLSB
- DELAY_UNIT_P, 12000, clk_i cycles per delay-entry unit (1 ms at 12 MHz)
- POLL_TIMEOUT_P, 65535, max clk_i cycles spent polling I2CSR for one event

Ports:
- clk_i  in  1  system clock (mclk_i domain)
- rstn_i  in  1  async active-low reset
- start_i  in  1  pulse: (re)run full sequence; ignored while busy_o=1
- tbl_addr_o  out  $clog2(NUM_REGS_P)  table index
- tbl_data_i  in  24  {reg_addr[15:0], value[7:0]}, valid 1 cycle after tbl_addr_o changes
- sbstb_o  out  1  SB_I2C SBSTBI
- sbrw_o  out  1  SB_I2C SBRWI (1=write)
- sbadr_o  out  8  SB_I2C SBADRI[7:0]
- sbdat_o  out  8  SB_I2C SBDATI[7:0]
- sbdat_i  in  8  SB_I2C SBDATO[7:0]
- sback_i  in  1  SB_I2C SBACKO
- busy_o  out  1  sequence running
- done_o  out  1  sequence completed without error (sticky until start_i)
- err_o  out  1  NACK or timeout (sticky until start_i)
- err_idx_o  out  $clog2(NUM_REGS_P)  table index at error

Behaviour:
- Reset (async assert, sync deassert upstream): all outputs 0, state IDLE. No automatic start; start_i required.
- Bus access: drive sbadr_o/sbdat_o/sbrw_o, assert sbstb_o; hold stable until sback_i=1; deassert sbstb_o the cycle after ack; at least one idle cycle between accesses. Reads latch sbdat_i in the ack cycle.
- Register map (BUS_ADDR74=0001): CR1 0x18, CMDR 0x19, BRLSB 0x1A, BRMSB 0x1B, SR 0x1C, TXDR 0x1D.
- CMDR bits: STA=0x80, STO=0x40, WR=0x10. SR bits: TIP=7, BUSY=6, RARC=5, TRRDY=2. CR1 enable=0x80.
- States: IDLE -> INIT (write BRLSB=BR_DIV_P[7:0], BRMSB=BR_DIV_P[9:8], CR1=0x80) -> FETCH -> {DELAY | XFER} -> NEXT -> ... -> DONE or ERR.
- FETCH: present index, wait 1 cycle, latch tbl_data_i. If reg_addr==16'hFFFF, go to DELAY. Otherwise go to XFER.
- XFER byte sequence:
  - TXDR=(DEV_ADDR_P<<1)|0, CMDR=STA|WR, poll SR until TRRDY=1.
  - Then addr_hi, addr_lo, value: each as TXDR write, CMDR=WR, poll TRRDY.
  - Then CMDR=STO, poll until BUSY=0.
- After each TRRDY poll: if RARC=1, issue CMDR=STO, then go to ERR.
- Poll counter resets per event. Reaching POLL_TIMEOUT_P goes to ERR without STO.
- DELAY: count value*DELAY_UNIT_P cycles; value 0 means zero wait (straight to NEXT).
- NEXT: if index==NUM_REGS_P-1, go to DONE (done_o=1, busy_o=0). Else increment and go to FETCH.
- ERR: err_o=1, err_idx_o=current index, busy_o=0.
- busy_o=1 from the cycle after start_i through entry to DONE/ERR.
- start_i in DONE/ERR clears done_o/err_o and restarts at INIT with index 0.
- Reset mid-transfer: immediate return to IDLE with sbstb_o=0; the I2C core is reinitialised on the next run.

Test Plan:
- SB_I2C bus model acks after 2 cycles, TRRDY after 20, no NACK; 3-entry table {0x0103,0x01},{0xFFFF,0x02},{0x3024,0x05}, DELAY_UNIT_P=100 -> writes BRLSB=0x3C, BRMSB=0x00, CR1=0x80; TXDR bytes 0x48,0x01,0x03,0x01 then STO; ≥200-cycle gap; then 0x48,0x30,0x24,0x05; done_o=1, err_o=0.
- Model sets RARC after the addr_hi byte of entry 1 -> CMDR=0x40 written, err_o=1, err_idx_o=1, busy_o=0, no further TXDR writes.
- Model never sets TRRDY, POLL_TIMEOUT_P=50 -> err_o=1 within 50+overhead cycles of the first CMDR=0x90; sbstb_o=0 afterward.
- Model delays sback_i 7 cycles -> sbadr_o/sbdat_o/sbstb_o stay stable the whole time; strobe drops the cycle after ack.
- rstn_i asserted mid-XFER, then start_i -> outputs zero asynchronously; rerun starts with BRLSB write and completes with done_o=1.
- start_i pulsed while busy_o=1 -> ignored, sequence unchanged; start_i after ERR -> err_o cleared, full rerun.
